wb_queue: RTL and testbench

Write-back queue between the execute/memory stages and the register file's single write port. Completed results (destination index + data) are accepted through a valid/ready handshake, buffered in a DEPTH-entry FIFO, and drained one per cycle to the register file. It also forwards pending (not-yet-written) values to the operand read path, so the decode stage never reads a stale register.

---
 rtl/wb_queue.sv | 117 +++++++++++
 tb/tb_wb_queue.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// wb_queue: write-back buffer between execute/memory and the register file's
// single write port. Results are buffered in a small FIFO, drained one per
// cycle, and pending values are forwarded to the two decode read ports.
//
// Handshake: a result transfers on a rising edge where in_valid && in_ready;
// in_ready never depends on in_valid. The write side has no back-pressure:
// the register file takes the head whenever wr_en is high.
module wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IDX_W-1:0]         in_idx,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     drain_hold,
  output logic                     wr_en,
  output logic [IDX_W-1:0]         wr_reg_index,
  output logic [DATA_W-1:0]        wr_reg_data,
  input  logic [IDX_W-1:0]         rd_idx_1,
  input  logic [IDX_W-1:0]         rd_idx_2,
  output logic                     fwd_hit_1,
  output logic                     fwd_hit_2,
  output logic [DATA_W-1:0]        fwd_data_1,
  output logic [DATA_W-1:0]        fwd_data_2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [IDX_W-1:0]  idx_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  cnt_q;

  logic full, accept, push, pop;

  // Full blocks acceptance even when a pop happens in the same cycle.
  assign full   = (cnt_q == CNT_W'(DEPTH));
  assign in_ready = rst & ~full;
  assign accept = in_valid & in_ready;
  // Writes to register 0 complete the handshake but are never stored.
  assign push   = accept & (in_idx != '0);
  assign wr_en  = (cnt_q != '0) & ~drain_hold;
  assign pop    = wr_en;

  assign wr_reg_index = idx_q[head_q];
  assign wr_reg_data  = data_q[head_q];
  assign count        = cnt_q;

  // Pointers, occupancy and per-entry valid bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
    end else begin
      if (push) begin
        tail_q        <= tail_q + PTR_W'(1);
        vld_q[tail_q] <= 1'b1;
      end
      if (pop) begin
        head_q        <= head_q + PTR_W'(1);
        vld_q[head_q] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Entry payload; deliberately not reset, only the valid bits matter.
  always_ff @(posedge clk) begin
    if (push) begin
      idx_q[tail_q]  <= in_idx;
      data_q[tail_q] <= in_data;
    end
  end

  logic [1:0][IDX_W-1:0]  rd_idx;
  logic [1:0]             hit;
  logic [1:0][DATA_W-1:0] fdat;
  logic [PTR_W-1:0]       slot;

  assign rd_idx[0] = rd_idx_1;
  assign rd_idx[1] = rd_idx_2;

  // Forwarding: walk oldest to youngest from head so the last match wins.
  always_comb begin
    hit  = '0;
    fdat = '0;
    slot = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot = head_q + PTR_W'(i);
        if (vld_q[slot] && (idx_q[slot] == rd_idx[p]) && (rd_idx[p] != '0)) begin
          hit[p]  = 1'b1;
          fdat[p] = data_q[slot];
        end
      end
    end
  end

  assign fwd_hit_1  = hit[0];
  assign fwd_hit_2  = hit[1];
  assign fwd_data_1 = fdat[0];
  assign fwd_data_2 = fdat[1];

endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: scoreboard bench for wb_queue. A reference model (expected
// queue plus occupancy) is updated at each falling edge from the driven
// stimulus and compared against every DUT output.
module tb_wb_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 5;
  localparam int E_W    = IDX_W + DATA_W;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [IDX_W-1:0]  in_idx;
  logic [DATA_W-1:0] in_data;
  logic              drain_hold;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_reg_index;
  logic [DATA_W-1:0] wr_reg_data;
  logic [IDX_W-1:0]  rd_idx_1, rd_idx_2;
  logic              fwd_hit_1, fwd_hit_2;
  logic [DATA_W-1:0] fwd_data_1, fwd_data_2;
  logic [$clog2(DEPTH):0] count;

  wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx), .in_data(in_data),
    .drain_hold(drain_hold),
    .wr_en(wr_en), .wr_reg_index(wr_reg_index), .wr_reg_data(wr_reg_data),
    .rd_idx_1(rd_idx_1), .rd_idx_2(rd_idx_2),
    .fwd_hit_1(fwd_hit_1), .fwd_hit_2(fwd_hit_2),
    .fwd_data_1(fwd_data_1), .fwd_data_2(fwd_data_2),
    .count(count)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [E_W-1:0] exp_q[$];
  int mdl_cnt = 0;

  // Clock and reset.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Youngest pending value for an index, from the expected queue.
  function automatic void fwd_model(input logic [IDX_W-1:0] rd, output logic h,
                                    output logic [DATA_W-1:0] d);
    h = 1'b0;
    d = '0;
    if (rd != '0) begin
      foreach (exp_q[k]) begin
        if (exp_q[k][E_W-1:DATA_W] == rd) begin
          h = 1'b1;
          d = exp_q[k][DATA_W-1:0];
        end
      end
    end
  endfunction

  // Driver: apply one cycle of inputs just after a rising edge.
  task automatic step(input logic v, input logic [IDX_W-1:0] idx,
                      input logic [DATA_W-1:0] data, input logic hold);
    @(posedge clk);
    #1;
    in_valid   = v;
    in_idx     = idx;
    in_data    = data;
    drain_hold = hold;
  endtask

  // Scoreboard: compare outputs against the model, then advance the model.
  initial begin
    logic exp_ready, exp_wr, h;
    logic [DATA_W-1:0] d;
    logic [E_W-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_q.delete();
        mdl_cnt = 0;
      end else begin
        exp_ready = (mdl_cnt != DEPTH);
        exp_wr    = (mdl_cnt != 0) && !drain_hold;
        chk("in_ready", in_ready, exp_ready);
        chk("count", count, mdl_cnt);
        chk("wr_en", wr_en, exp_wr);
        fwd_model(rd_idx_1, h, d);
        chk("fwd_hit_1", fwd_hit_1, h);
        chk("fwd_data_1", fwd_data_1, d);
        fwd_model(rd_idx_2, h, d);
        chk("fwd_hit_2", fwd_hit_2, h);
        chk("fwd_data_2", fwd_data_2, d);
        if (exp_wr) begin
          e = exp_q.pop_front();
          chk("wr_reg_index", wr_reg_index, e[E_W-1:DATA_W]);
          chk("wr_reg_data", wr_reg_data, e[DATA_W-1:0]);
          mdl_cnt--;
        end
        if (in_valid && exp_ready && in_idx != '0) begin
          exp_q.push_back({in_idx, in_data});
          mdl_cnt++;
        end
      end
    end
  end

  // Main sequence.
  initial begin
    in_valid = 1'b0; in_idx = '0; in_data = '0; drain_hold = 1'b0;
    rd_idx_1 = '0; rd_idx_2 = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #10;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_wr_en", wr_en, 1'b0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1 chk("post_rst_in_ready", in_ready, 1'b1);

    // Reset/basic: single push, visible on the write port the next cycle.
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    @(negedge clk); #1;
    chk("basic_wr_en", wr_en, 1'b1);
    chk("basic_idx", wr_reg_index, 5);
    chk("basic_data", wr_reg_data, 32'hDEADBEEF);
    step(1'b0, '0, '0, 1'b0);
    @(negedge clk); #1;
    chk("basic_empty_count", count, 0);
    chk("basic_empty_wr_en", wr_en, 1'b0);

    // Fill/full with hold, then a rejected push while draining.
    for (int i = 1; i <= 4; i++) step(1'b1, IDX_W'(i), 32'h100 + DATA_W'(i), 1'b1);
    step(1'b1, 5'd9, 32'h999, 1'b1);
    @(negedge clk); #1;
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 1'b0);
    step(1'b1, 5'd9, 32'h999, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    repeat (5) step(1'b0, '0, '0, 1'b0);

    // Index 0 is consumed but dropped.
    step(1'b1, 5'd0, 32'h1234, 1'b0);
    step(1'b1, 5'd7, 32'h55, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    @(negedge clk); #1;
    chk("idx0_wr_idx", wr_reg_index, 7);
    repeat (2) step(1'b0, '0, '0, 1'b0);

    // Forward youngest.
    rd_idx_1 = 5'd3; rd_idx_2 = 5'd0;
    step(1'b1, 5'd3, 32'hA, 1'b1);
    step(1'b1, 5'd3, 32'hB, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    @(negedge clk); #1;
    chk("fwd_young_hit", fwd_hit_1, 1'b1);
    chk("fwd_young_data", fwd_data_1, 32'hB);
    chk("fwd_zero_hit", fwd_hit_2, 1'b0);
    repeat (3) step(1'b0, '0, '0, 1'b0);

    // Back-to-back stream across pointer wrap.
    rd_idx_2 = 5'd12;
    for (int i = 0; i < 10; i++) step(1'b1, IDX_W'(10 + i), 32'hC000 + DATA_W'(i), 1'b0);
    step(1'b0, '0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b0);

    // Reset mid-operation with three entries pending.
    rd_idx_1 = 5'd21;
    step(1'b1, 5'd20, 32'h20, 1'b1);
    step(1'b1, 5'd21, 32'h21, 1'b1);
    step(1'b1, 5'd22, 32'h22, 1'b1);
    step(1'b0, '0, '0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_wr_en", wr_en, 1'b0);
    chk("mid_rst_fwd_hit", fwd_hit_1, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (4) step(1'b0, '0, '0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 120; i++) begin
      rd_idx_1 = IDX_W'($urandom_range(0, 7));
      rd_idx_2 = IDX_W'($urandom_range(0, 7));
      step(1'($urandom_range(0, 1)), IDX_W'($urandom_range(0, 7)),
           $urandom, 1'($urandom_range(0, 3) == 0));
    end
    repeat (8) step(1'b0, '0, '0, 1'b0);
    @(negedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
